alu_operand_stage: RTL and testbench

- ID/EX boundary stage directly upstream of the ALU: takes decoded instruction fields and register-file read data, and produces the ALU operands A and B plus the 4-bit ALU Op.
- Performs immediate extension, B-operand select and opcode/func-to-Op mapping.
- Registers the results behind a valid/ready handshake with a one-entry skid buffer, so stalls from EX never drop a beat.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/operand_decode.sv | 57 +++++
 rtl/alu_operand_stage.sv | 100 ++++++++++
 tb/tb_alu_operand_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes, instruction opcodes and operand-extension kinds
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_ROL = 4'b1100;
  localparam logic [3:0] OP_ROR = 4'b1101;

  localparam logic [5:0] OPC_RTYPE = 6'b100000;
  localparam logic [5:0] OPC_ADDI  = 6'b110000;
  localparam logic [5:0] OPC_ANDI  = 6'b110010;
  localparam logic [5:0] OPC_ORI   = 6'b110011;
  localparam logic [5:0] OPC_LI    = 6'b111000;
  localparam logic [5:0] OPC_LUI   = 6'b111001;
  localparam logic [5:0] OPC_LW    = 6'b001111;
  localparam logic [5:0] OPC_SW    = 6'b011111;
  localparam logic [5:0] OPC_BEQ   = 6'b000000;
  localparam logic [5:0] OPC_BNE   = 6'b000001;
  localparam logic [5:0] OPC_B     = 6'b111111;

  // EXT_NONE selects the second register read port as operand B.
  typedef enum logic [1:0] {
    EXT_SIGN,
    EXT_ZERO,
    EXT_HIGH,
    EXT_NONE
  } ext_kind_t;

  function automatic logic func_legal(input logic [5:0] func);
    if (func[5:4] != 2'b11) return 1'b0;
    case (func[3:0])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT,
      OP_SRA, OP_SLL, OP_SRL, OP_ROL, OP_ROR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/operand_decode.sv
// rtl/operand_decode.sv - combinational opcode/func decode into ALU operands and op
module operand_decode
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [5:0]        opcode,
  input  logic [5:0]        func,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [3:0]        op,
  output logic              illegal
);

  ext_kind_t ext;
  logic      b_zero;

  always_comb begin
    a       = rs_data;
    ext     = EXT_NONE;
    b_zero  = 1'b0;
    op      = OP_ADD;
    illegal = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        if (func_legal(func)) op = func[3:0];
        else                  illegal = 1'b1;
      end
      OPC_ADDI: ext = EXT_SIGN;
      OPC_ANDI: begin op = OP_AND; ext = EXT_ZERO; end
      OPC_ORI:  begin op = OP_OR;  ext = EXT_ZERO; end
      OPC_LI:   begin a = '0;      ext = EXT_SIGN; end
      OPC_LUI:  begin a = '0; op = OP_OR; ext = EXT_HIGH; end
      OPC_LW, OPC_SW:   ext = EXT_SIGN;
      OPC_BEQ, OPC_BNE: op = OP_SUB;
      OPC_B:    begin a = '0; b_zero = 1'b1; end
      // Unknown opcodes still flow downstream, flagged, with R-type operands.
      default:  illegal = 1'b1;
    endcase
  end

  always_comb begin
    b = rt_data;
    case (ext)
      EXT_SIGN: b = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      EXT_ZERO: b = {{(DATA_W-IMM_W){1'b0}}, imm};
      EXT_HIGH: b = {imm, {(DATA_W-IMM_W){1'b0}}};
      default:  b = rt_data;
    endcase
    if (b_zero) b = '0;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX operand stage with valid/ready and one-entry skid buffer
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [5:0]        InOpcode,
  input  logic [5:0]        InFunc,
  input  logic [DATA_W-1:0] InRsData,
  input  logic [DATA_W-1:0] InRtData,
  input  logic [IMM_W-1:0]  InImm,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutA,
  output logic [DATA_W-1:0] OutB,
  output logic [3:0]        OutOp,
  output logic [DATA_W-1:0] OutStoreData,
  output logic              OutIllegal
);

  logic [DATA_W-1:0] dec_a, dec_b;
  logic [3:0]        dec_op;
  logic              dec_illegal;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_a, skid_b, skid_store;
  logic [3:0]        skid_op;
  logic              skid_illegal;

  logic accept;

  operand_decode #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_decode (
    .opcode  (InOpcode),
    .func    (InFunc),
    .rs_data (InRsData),
    .rt_data (InRtData),
    .imm     (InImm),
    .a       (dec_a),
    .b       (dec_b),
    .op      (dec_op),
    .illegal (dec_illegal)
  );

  assign InReady = !skid_valid;
  assign accept  = InValid && InReady;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      OutValid     <= 1'b0;
      OutA         <= '0;
      OutB         <= '0;
      OutOp        <= OP_ADD;
      OutStoreData <= '0;
      OutIllegal   <= 1'b0;
      skid_valid   <= 1'b0;
      skid_a       <= '0;
      skid_b       <= '0;
      skid_op      <= OP_ADD;
      skid_store   <= '0;
      skid_illegal <= 1'b0;
    end else if (Flush) begin
      OutValid   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (OutValid && !OutReady) begin
      // Output is stalled: hold it, park a newly accepted beat in the skid.
      if (accept) begin
        skid_valid   <= 1'b1;
        skid_a       <= dec_a;
        skid_b       <= dec_b;
        skid_op      <= dec_op;
        skid_store   <= InRtData;
        skid_illegal <= dec_illegal;
      end
    end else if (skid_valid) begin
      OutValid     <= 1'b1;
      OutA         <= skid_a;
      OutB         <= skid_b;
      OutOp        <= skid_op;
      OutStoreData <= skid_store;
      OutIllegal   <= skid_illegal;
      skid_valid   <= 1'b0;
    end else if (accept) begin
      OutValid     <= 1'b1;
      OutA         <= dec_a;
      OutB         <= dec_b;
      OutOp        <= dec_op;
      OutStoreData <= InRtData;
      OutIllegal   <= dec_illegal;
    end else begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed vector bench for alu_operand_stage
module tb_alu_operand_stage;

  logic        Clk = 1'b0;
  logic        Reset, Flush, InValid, InReady, OutValid, OutReady, OutIllegal;
  logic [5:0]  InOpcode, InFunc;
  logic [31:0] InRsData, InRtData, OutA, OutB, OutStoreData;
  logic [15:0] InImm;
  logic [3:0]  OutOp;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  alu_operand_stage #(.DATA_W(32), .IMM_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .InValid(InValid), .InReady(InReady),
    .InOpcode(InOpcode), .InFunc(InFunc),
    .InRsData(InRsData), .InRtData(InRtData), .InImm(InImm),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutA(OutA), .OutB(OutB), .OutOp(OutOp),
    .OutStoreData(OutStoreData), .OutIllegal(OutIllegal)
  );

  typedef struct {
    string       name;
    logic [5:0]  opc;
    logic [5:0]  func;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [3:0]  exp_op;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] opc, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm);
    InValid  = v;
    InOpcode = opc;
    InFunc   = 6'b000000;
    InRsData = rs;
    InRtData = rt;
    InImm    = imm;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{"addi",    6'b110000, 6'b000000, 32'd5,         32'd0,  16'hFFFF, 32'd5,         32'hFFFFFFFF, 4'b0000, 1'b0};
    vecs[1]  = '{"ori",     6'b110011, 6'b000000, 32'h10,        32'd0,  16'h8001, 32'h10,        32'h00008001, 4'b0011, 1'b0};
    vecs[2]  = '{"lui",     6'b111001, 6'b000000, 32'hAAAA,      32'd0,  16'h1234, 32'd0,         32'h12340000, 4'b0011, 1'b0};
    vecs[3]  = '{"rt_ror",  6'b100000, 6'b111101, 32'h80000001,  32'd7,  16'h0000, 32'h80000001,  32'd7,        4'b1101, 1'b0};
    vecs[4]  = '{"rt_bad",  6'b100000, 6'b110101, 32'd1,         32'd2,  16'h0000, 32'd1,         32'd2,        4'b0000, 1'b1};
    vecs[5]  = '{"andi",    6'b110010, 6'b000000, 32'd3,         32'd0,  16'hF00F, 32'd3,         32'h0000F00F, 4'b0010, 1'b0};
    vecs[6]  = '{"li",      6'b111000, 6'b000000, 32'd99,        32'd0,  16'h8000, 32'd0,         32'hFFFF8000, 4'b0000, 1'b0};
    vecs[7]  = '{"lw",      6'b001111, 6'b000000, 32'd100,       32'd0,  16'h7FFC, 32'd100,       32'h00007FFC, 4'b0000, 1'b0};
    vecs[8]  = '{"sw",      6'b011111, 6'b000000, 32'd4,         32'd55, 16'hFFFC, 32'd4,         32'hFFFFFFFC, 4'b0000, 1'b0};
    vecs[9]  = '{"beq",     6'b000000, 6'b000000, 32'd9,         32'd9,  16'h1111, 32'd9,         32'd9,        4'b0001, 1'b0};
    vecs[10] = '{"bne",     6'b000001, 6'b000000, 32'd3,         32'd8,  16'h2222, 32'd3,         32'd8,        4'b0001, 1'b0};
    vecs[11] = '{"b",       6'b111111, 6'b000000, 32'd5,         32'd6,  16'h3333, 32'd0,         32'd0,        4'b0000, 1'b0};
    vecs[12] = '{"bad_opc", 6'b000010, 6'b000000, 32'd7,         32'd8,  16'h4444, 32'd7,         32'd8,        4'b0000, 1'b1};
    vecs[13] = '{"rt_hi00", 6'b100000, 6'b001000, 32'd1,         32'd2,  16'h0000, 32'd1,         32'd2,        4'b0000, 1'b1};
    vecs[14] = '{"rt_sra",  6'b100000, 6'b111000, 32'hF0,        32'd4,  16'h0000, 32'hF0,        32'd4,        4'b1000, 1'b0};

    Flush = 1'b0;
    OutReady = 1'b1;
    drive(1'b0, 6'b0, 32'd0, 32'd0, 16'd0);
    do_reset();
    #1;
    check("rst_out_valid", {31'd0, OutValid}, 32'd0);
    check("rst_in_ready", {31'd0, InReady}, 32'd1);
    check("rst_out_a", OutA, 32'd0);
    check("rst_out_op", {28'd0, OutOp}, 32'd0);
    check("rst_illegal", {31'd0, OutIllegal}, 32'd0);

    // Streamed vectors: each one appears on the outputs one edge after it is driven.
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, vecs[i].opc, vecs[i].rs, vecs[i].rt, vecs[i].imm);
      InFunc = vecs[i].func;
      step();
      check({vecs[i].name, "_valid"}, {31'd0, OutValid}, 32'd1);
      check({vecs[i].name, "_a"}, OutA, vecs[i].exp_a);
      check({vecs[i].name, "_b"}, OutB, vecs[i].exp_b);
      check({vecs[i].name, "_op"}, {28'd0, OutOp}, {28'd0, vecs[i].exp_op});
      check({vecs[i].name, "_ill"}, {31'd0, OutIllegal}, {31'd0, vecs[i].exp_ill});
      check({vecs[i].name, "_store"}, OutStoreData, vecs[i].rt);
    end
    InValid = 1'b0;
    step();
    check("idle_valid", {31'd0, OutValid}, 32'd0);

    // Backpressure: three beats with EX stalling after the first.
    drive(1'b1, 6'b110000, 32'd1, 32'd0, 16'd0);
    step();
    OutReady = 1'b0;
    drive(1'b1, 6'b110000, 32'd2, 32'd0, 16'd0);
    check("bp_ready_before_2", {31'd0, InReady}, 32'd1);
    step();
    check("bp_ready_low", {31'd0, InReady}, 32'd0);
    check("bp_hold_a1", OutA, 32'd1);
    drive(1'b1, 6'b110000, 32'd3, 32'd0, 16'd0);
    step();
    check("bp_ready_still_low", {31'd0, InReady}, 32'd0);
    check("bp_still_a1", OutA, 32'd1);
    check("bp_still_valid", {31'd0, OutValid}, 32'd1);
    OutReady = 1'b1;
    step();
    check("bp_out_a2", OutA, 32'd2);
    check("bp_ready_back", {31'd0, InReady}, 32'd1);
    step();
    check("bp_out_a3", OutA, 32'd3);
    check("bp_out3_valid", {31'd0, OutValid}, 32'd1);
    InValid = 1'b0;
    step();
    check("bp_drained", {31'd0, OutValid}, 32'd0);

    // Flush with output and skid both full and a beat presented.
    OutReady = 1'b0;
    drive(1'b1, 6'b110000, 32'd10, 32'd0, 16'd0);
    step();
    drive(1'b1, 6'b110000, 32'd11, 32'd0, 16'd0);
    step();
    check("fl_skid_full", {31'd0, InReady}, 32'd0);
    drive(1'b1, 6'b110000, 32'd12, 32'd0, 16'd0);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    check("fl_valid", {31'd0, OutValid}, 32'd0);
    check("fl_ready", {31'd0, InReady}, 32'd1);
    OutReady = 1'b1;
    drive(1'b1, 6'b110000, 32'd13, 32'd0, 16'd0);
    step();
    check("fl_next_valid", {31'd0, OutValid}, 32'd1);
    check("fl_next_a", OutA, 32'd13);
    InValid = 1'b0;
    step();
    check("fl_alone", {31'd0, OutValid}, 32'd0);

    // Flush discards a beat even when the stage is ready for it.
    OutReady = 1'b0;
    drive(1'b1, 6'b110000, 32'd14, 32'd0, 16'd0);
    step();
    drive(1'b1, 6'b110000, 32'd15, 32'd0, 16'd0);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    InValid = 1'b0;
    OutReady = 1'b1;
    check("fl2_valid", {31'd0, OutValid}, 32'd0);
    step();
    check("fl2_no_skid_beat", {31'd0, OutValid}, 32'd0);

    // Reset while stalled with the skid full.
    OutReady = 1'b0;
    drive(1'b1, 6'b110000, 32'd20, 32'd0, 16'd0);
    step();
    drive(1'b1, 6'b110000, 32'd21, 32'd0, 16'd0);
    step();
    InValid = 1'b0;
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("rs_valid", {31'd0, OutValid}, 32'd0);
    check("rs_ready", {31'd0, InReady}, 32'd1);
    check("rs_a", OutA, 32'd0);
    OutReady = 1'b1;
    step();
    check("rs_no_ghost", {31'd0, OutValid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
